vl555_rc_model: RTL and testbench

Clocked digital model of the 555 timing capacitor and its two window comparators. It is the plant-side counterpart of the 555 control logic: it consumes that logic's `Q` output (discharge control) and produces its `Trigger` and `Threshold` inputs. This closes the astable loop in all-digital Verilator runs with no analog solver. It also optionally measures the resulting high and low times of `Q`.

---
 rtl/vl555_rc_model.sv | 159 +++++++++++++++
 tb/tb_vl555_rc_model.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vl555_rc_model.sv
// Clocked model of the 555 timing capacitor and its trigger/threshold comparators.
// Optional Q high/low time measurement is built only when VL555_RC_MEAS_EN is defined.
module vl555_rc_model #(
    parameter int WIDTH     = 12,
    parameter int CHG_SHIFT = 4,
    parameter int DIS_SHIFT = 4,
    parameter int CWIDTH    = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Q,
    output logic [WIDTH-1:0]  Cap,
    output logic              Trigger,
    output logic              Threshold,
    output logic [CWIDTH-1:0] HighTime,
    output logic [CWIDTH-1:0] LowTime,
    output logic              MeasValid
);

    localparam logic [WIDTH-1:0] FULL   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   FULL_X = {1'b0, FULL};
    localparam logic [WIDTH:0]   THREE  = {{(WIDTH-1){1'b0}}, 2'b11};
    localparam logic [WIDTH-1:0] T_LO   = WIDTH'(FULL_X / THREE);
    localparam logic [WIDTH-1:0] T_HI   = WIDTH'({FULL, 1'b0} / THREE);

    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic             trigger_q;
    logic             trigger_d;
    logic             threshold_q;
    logic             threshold_d;
    logic [WIDTH-1:0] room_s;
    logic [WIDTH-1:0] chg_step_s;
    logic [WIDTH-1:0] dis_step_s;

    // Next capacitor voltage; minimum unit step lets the ramp reach the rails exactly.
    always_comb begin
        room_s     = FULL - cap_q;
        chg_step_s = room_s >> CHG_SHIFT;
        dis_step_s = cap_q >> DIS_SHIFT;
        if ((chg_step_s == '0) && (room_s != '0)) begin
            chg_step_s = ONE;
        end else begin
            chg_step_s = room_s >> CHG_SHIFT;
        end
        if ((dis_step_s == '0) && (cap_q != '0)) begin
            dis_step_s = ONE;
        end else begin
            dis_step_s = cap_q >> DIS_SHIFT;
        end
        if (Enable) begin
            if (Q) begin
                cap_d = cap_q + chg_step_s;
            end else begin
                cap_d = cap_q - dis_step_s;
            end
        end else begin
            cap_d = cap_q;
        end
        trigger_d   = (cap_d < T_LO);
        threshold_d = (cap_d >= T_HI);
    end

    // Capacitor and comparator registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cap_q       <= '0;
            trigger_q   <= 1'b1;
            threshold_q <= 1'b0;
        end else begin
            cap_q       <= cap_d;
            trigger_q   <= trigger_d;
            threshold_q <= threshold_d;
        end
    end

    assign Cap       = cap_q;
    assign Trigger   = trigger_q;
    assign Threshold = threshold_q;

`ifdef VL555_RC_MEAS_EN
    localparam logic [CWIDTH-1:0] CMAX  = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] C_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

    logic              qd_q;
    logic              qd_d;
    logic [CWIDTH-1:0] hi_cnt_q;
    logic [CWIDTH-1:0] hi_cnt_d;
    logic [CWIDTH-1:0] lo_cnt_q;
    logic [CWIDTH-1:0] lo_cnt_d;
    logic [CWIDTH-1:0] high_time_q;
    logic [CWIDTH-1:0] high_time_d;
    logic [CWIDTH-1:0] low_time_q;
    logic [CWIDTH-1:0] low_time_d;
    logic              meas_valid_q;
    logic              meas_valid_d;
    logic [CWIDTH-1:0] en_cnt_s;

    // Phase counters; the edge cycle itself opens the new phase's count.
    always_comb begin
        qd_d         = Q;
        en_cnt_s     = {{(CWIDTH-1){1'b0}}, Enable};
        hi_cnt_d     = hi_cnt_q;
        lo_cnt_d     = lo_cnt_q;
        high_time_d  = high_time_q;
        low_time_d   = low_time_q;
        meas_valid_d = 1'b0;
        if (qd_q && !Q) begin
            high_time_d  = hi_cnt_q;
            hi_cnt_d     = '0;
            lo_cnt_d     = en_cnt_s;
            meas_valid_d = 1'b1;
        end else if (!qd_q && Q) begin
            low_time_d   = lo_cnt_q;
            lo_cnt_d     = '0;
            hi_cnt_d     = en_cnt_s;
            meas_valid_d = 1'b1;
        end else if (Enable) begin
            if (Q) begin
                hi_cnt_d = (hi_cnt_q == CMAX) ? hi_cnt_q : hi_cnt_q + C_ONE;
            end else begin
                lo_cnt_d = (lo_cnt_q == CMAX) ? lo_cnt_q : lo_cnt_q + C_ONE;
            end
        end else begin
            meas_valid_d = 1'b0;
        end
    end

    // Measurement registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            qd_q         <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            high_time_q  <= '0;
            low_time_q   <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            qd_q         <= qd_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            high_time_q  <= high_time_d;
            low_time_q   <= low_time_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    assign HighTime  = high_time_q;
    assign LowTime   = low_time_q;
    assign MeasValid = meas_valid_q;
`else
    assign HighTime  = '0;
    assign LowTime   = '0;
    assign MeasValid = 1'b0;
`endif

endmodule

// File: tb/tb_vl555_rc_model.sv
// Self-checking bench for vl555_rc_model (WIDTH=8, shifts of 2): directed plan plus random Q/Enable.
module tb_vl555_rc_model;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Q;
    logic [7:0]  Cap;
    logic        Trigger;
    logic        Threshold;
    logic [15:0] HighTime;
    logic [15:0] LowTime;
    logic        MeasValid;

    int vectors     = 0;
    int miscompares = 0;

    int m_cap;
    int m_hi;
    int m_lo;
    int m_mv;
    bit q_hist[$];
    bit en_hist[$];

    vl555_rc_model #(.WIDTH(8), .CHG_SHIFT(2), .DIS_SHIFT(2), .CWIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Q(Q),
        .Cap(Cap), .Trigger(Trigger), .Threshold(Threshold),
        .HighTime(HighTime), .LowTime(LowTime), .MeasValid(MeasValid)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cap", {24'd0, Cap}, m_cap);
        chk("trigger", {31'd0, Trigger}, (m_cap < 85) ? 1 : 0);
        chk("threshold", {31'd0, Threshold}, (m_cap >= 170) ? 1 : 0);
`ifdef VL555_RC_MEAS_EN
        chk("high_time", {16'd0, HighTime}, m_hi);
        chk("low_time", {16'd0, LowTime}, m_lo);
        chk("meas_valid", {31'd0, MeasValid}, m_mv);
`else
        chk("high_time_off", {16'd0, HighTime}, 0);
        chk("low_time_off", {16'd0, LowTime}, 0);
        chk("meas_valid_off", {31'd0, MeasValid}, 0);
`endif
    endtask

    // Reference: capacitor rules in plain integers; durations recovered from Q/Enable history.
    task automatic model_step(input bit q, input bit en);
        int d;
        int cnt;
        bit prev;
        if (en) begin
            if (q) begin
                d = (255 - m_cap) >> 2;
                if (d == 0 && m_cap < 255) d = 1;
                m_cap = m_cap + d;
            end else begin
                d = m_cap >> 2;
                if (d == 0 && m_cap > 0) d = 1;
                m_cap = m_cap - d;
            end
        end
        prev = (q_hist.size() > 0) ? q_hist[q_hist.size()-1] : 1'b0;
        m_mv = 0;
        if (q != prev) begin
            cnt = 0;
            for (int j = q_hist.size() - 1; j >= 0; j--) begin
                if (q_hist[j] != prev) break;
                if (en_hist[j]) cnt++;
            end
            if (cnt > 65535) cnt = 65535;
            if (prev) m_hi = cnt;
            else      m_lo = cnt;
            m_mv = 1;
        end
        q_hist.push_back(q);
        en_hist.push_back(en);
    endtask

    task automatic do_reset(input int n, input bit q, input bit en);
        for (int i = 0; i < n; i++) begin
            Reset  = 1'b1;
            Q      = q;
            Enable = en;
            @(posedge Clock);
            #1;
            m_cap = 0; m_hi = 0; m_lo = 0; m_mv = 0;
            q_hist.delete();
            en_hist.delete();
            check_all();
        end
        Reset = 1'b0;
    endtask

    task automatic step(input bit q, input bit en);
        Q      = q;
        Enable = en;
        @(posedge Clock);
        #1;
        model_step(q, en);
        check_all();
    endtask

    initial begin
        int exp_chg [4];
        int exp_dis [4];
        bit rq;
        bit ren;
        exp_chg = '{63, 111, 147, 174};
        exp_dis = '{192, 144, 108, 81};
        Reset = 1'b1; Enable = 1'b0; Q = 1'b0;

        // Plan 1: reset for two cycles, release with Q=0, Enable=1.
        do_reset(2, 1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset_cap", {24'd0, Cap}, 0);
        chk("reset_trig", {31'd0, Trigger}, 1);

        // Plan 2: charge sequence from 0.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            chk("chg_seq", {24'd0, Cap}, exp_chg[i]);
        end
        // Plan 3: hold charge to the rail.
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        chk("chg_full", {24'd0, Cap}, 255);
        chk("chg_full_thr", {31'd0, Threshold}, 1);

        // Plan 4: discharge sequence from 255, then down to 0.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("dis_seq", {24'd0, Cap}, exp_dis[i]);
        end
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        chk("dis_empty", {24'd0, Cap}, 0);

        // Plan 5: freeze mid-charge, then reset mid-ramp.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            chk("freeze_cap", {24'd0, Cap}, 147);
        end
        do_reset(1, 1'b1, 1'b1);
        chk("midramp_reset_trig", {31'd0, Trigger}, 1);

        // Plan 6: 10 high / 6 low periods after a discarded first period.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 1'b1);
`ifdef VL555_RC_MEAS_EN
                if (i == 0 && p > 0) chk("low_time_6", {16'd0, LowTime}, 6);
`endif
            end
            for (int i = 0; i < 6; i++) begin
                step(1'b0, 1'b1);
`ifdef VL555_RC_MEAS_EN
                if (i == 0) chk("high_time_10", {16'd0, HighTime}, 10);
`endif
            end
        end

        // Random Q runs, sparse Enable drops and occasional resets.
        rq = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1, rq, 1'b1);
            end else begin
                if ($urandom_range(0, 7) == 0) rq = ~rq;
                ren = ($urandom_range(0, 4) != 0);
                step(rq, ren);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
